pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder.sv | 119 +++++++++++
 tb/tb_pipe_adder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// Carry-pipelined adder/subtractor: WIDTH bits split into SEG ripple segments,
// one segment per stage, with input skew and output deskew so results emerge aligned.
module pipe_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_ci,
    input  logic             i_sub,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_s,
    output logic             o_co,
    output logic             o_ovf
);
    localparam int W = WIDTH / SEG;

    // Ripple add of one W-bit segment; returns {carry_out, sum}.
    function automatic logic [W:0] seg_add(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic         ci);
        logic [W-1:0] s;
        logic         c;
        s = '0;
        c = ci;
        for (int i = 0; i < W; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        return {c, s};
    endfunction

    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    assign b_eff = i_sub ? ~i_b : i_b;
    assign c_eff = i_sub | i_ci;

    for (genvar k = 0; k < SEG; k++) begin : g_seg
        localparam int RW = WIDTH - k * W;
        localparam int SW = (k + 1) * W;

        logic [RW-1:0] a_cur;
        logic [RW-1:0] b_cur;
        logic          c_cur;
        logic          v_cur;
        logic [W:0]    r;
        logic [SW-1:0] s_nxt;
        logic [SW-1:0] s_p;
        logic          cy_p;
        logic          vld_p;

        if (k == 0) begin : g_head
            assign a_cur = i_a;
            assign b_cur = b_eff;
            assign c_cur = c_eff;
            assign v_cur = i_valid;
            assign s_nxt = r[W-1:0];
        end else begin : g_body
            assign a_cur = g_seg[k-1].g_fwd.a_p;
            assign b_cur = g_seg[k-1].g_fwd.b_p;
            assign c_cur = g_seg[k-1].cy_p;
            assign v_cur = g_seg[k-1].vld_p;
            assign s_nxt = {r[W-1:0], g_seg[k-1].s_p};
        end

        assign r = seg_add(a_cur[W-1:0], b_cur[W-1:0], c_cur);

        // Stage k+1 boundary: finished low sum bits, segment carry and valid
        always_ff @(posedge clk) begin
            if (rst) begin
                s_p   <= '0;
                cy_p  <= 1'b0;
                vld_p <= 1'b0;
            end else if (en) begin
                s_p   <= s_nxt;
                cy_p  <= r[W];
                vld_p <= v_cur;
            end
        end

        if (k < SEG - 1) begin : g_fwd
            logic [RW-W-1:0] a_p;
            logic [RW-W-1:0] b_p;

            // Unconsumed operand bits ride along to the next segment
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_p <= '0;
                    b_p <= '0;
                end else if (en) begin
                    a_p <= a_cur[RW-1:W];
                    b_p <= b_cur[RW-1:W];
                end
            end
        end else begin : g_tail
            logic ovf_p;

            // Carry into the MSB equals a^b^s at that bit, so ovf = that ^ carry out
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_p <= 1'b0;
                end else if (en) begin
                    ovf_p <= a_cur[W-1] ^ b_cur[W-1] ^ r[W-1] ^ r[W];
                end
            end
        end
    end

    assign o_valid = g_seg[SEG-1].vld_p;
    assign o_s     = g_seg[SEG-1].s_p;
    assign o_co    = g_seg[SEG-1].cy_p;
    assign o_ovf   = g_seg[SEG-1].g_tail.ovf_p;

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder: 16-bit/4-segment main instance plus
// 8-bit instances with 1, 2 and 8 segments for the parameter sweep.
module tb_pipe_adder;
    logic        clk = 1'b0;
    logic        rst, en, i_valid, i_ci, i_sub;
    logic [15:0] i_a, i_b;
    logic        o_valid, o_co, o_ovf;
    logic [15:0] o_s;

    logic        w_rst, w_en, w_valid, w_ci, w_sub;
    logic [7:0]  w_a, w_b;
    logic        v1, co1, ov1, v2, co2, ov2, v8, co8, ov8;
    logic [7:0]  s1, s2, s8;

    int n_tests = 0;
    int n_fail  = 0;

    localparam int NSW = 16384;
    logic [9:0] e8 [NSW];

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(16), .SEG(4)) dut (
        .clk(clk), .rst(rst), .en(en), .i_valid(i_valid), .i_a(i_a), .i_b(i_b),
        .i_ci(i_ci), .i_sub(i_sub), .o_valid(o_valid), .o_s(o_s), .o_co(o_co), .o_ovf(o_ovf)
    );
    pipe_adder #(.WIDTH(8), .SEG(1)) dut_s1 (
        .clk(clk), .rst(w_rst), .en(w_en), .i_valid(w_valid), .i_a(w_a), .i_b(w_b),
        .i_ci(w_ci), .i_sub(w_sub), .o_valid(v1), .o_s(s1), .o_co(co1), .o_ovf(ov1)
    );
    pipe_adder #(.WIDTH(8), .SEG(2)) dut_s2 (
        .clk(clk), .rst(w_rst), .en(w_en), .i_valid(w_valid), .i_a(w_a), .i_b(w_b),
        .i_ci(w_ci), .i_sub(w_sub), .o_valid(v2), .o_s(s2), .o_co(co2), .o_ovf(ov2)
    );
    pipe_adder #(.WIDTH(8), .SEG(8)) dut_s8 (
        .clk(clk), .rst(w_rst), .en(w_en), .i_valid(w_valid), .i_a(w_a), .i_b(w_b),
        .i_ci(w_ci), .i_sub(w_sub), .o_valid(v8), .o_s(s8), .o_co(co8), .o_ovf(ov8)
    );

    // Reference: returns {ovf, co, sum}
    function automatic logic [17:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic sub);
        logic [15:0] bb;
        logic        c0;
        logic [16:0] full;
        logic [15:0] low;
        bb   = sub ? ~b : b;
        c0   = sub ? 1'b1 : ci;
        full = {1'b0, a} + {1'b0, bb} + 17'(c0);
        low  = {1'b0, a[14:0]} + {1'b0, bb[14:0]} + 16'(c0);
        return {low[15] ^ full[16], full[16], full[15:0]};
    endfunction

    function automatic logic [9:0] ref8(input logic [7:0] a, input logic [7:0] b,
                                        input logic ci, input logic sub);
        logic [7:0] bb;
        logic       c0;
        logic [8:0] full;
        logic [7:0] low;
        bb   = sub ? ~b : b;
        c0   = sub ? 1'b1 : ci;
        full = {1'b0, a} + {1'b0, bb} + 9'(c0);
        low  = {1'b0, a[6:0]} + {1'b0, bb[6:0]} + 8'(c0);
        return {low[7] ^ full[8], full[8], full[7:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; i_valid = 1'b1; i_a = 16'h1234; i_b = 16'h1111;
        i_ci = 1'b1; i_sub = 1'b0;
        w_rst = 1'b1; w_en = 1'b1; w_valid = 1'b1; w_a = 8'h12; w_b = 8'h34;
        w_ci = 1'b0; w_sub = 1'b0;
        tick();
        tick();
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        n_tests++; if (o_s !== 16'h0) begin n_fail++; $display("FAIL reset_sum: got %h expected 0000", o_s); end
        n_tests++; if (o_co !== 1'b0) begin n_fail++; $display("FAIL reset_co: got %b expected 0", o_co); end
        n_tests++; if (o_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", o_ovf); end
        n_tests++; if ({v1, v2, v8} !== 3'b000) begin n_fail++; $display("FAIL reset_w8_valid: got %b expected 000", {v1, v2, v8}); end
        rst = 1'b0; i_valid = 1'b0; w_rst = 1'b0; w_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_tests++;
            if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_drop cyc %0d: got %b expected 0", c, o_valid); end
        end
    endtask

    task automatic test_directed();
        logic [15:0] ta [4];
        logic [15:0] tb [4];
        logic        ts [4];
        logic [17:0] te [4];
        int          lat;
        ta = '{16'hFFFF, 16'h0005, 16'h7FFF, 16'h8000};
        tb = '{16'h0001, 16'h0007, 16'h0001, 16'h0001};
        ts = '{1'b0, 1'b1, 1'b0, 1'b1};
        te = '{{1'b0, 1'b1, 16'h0000}, {1'b0, 1'b0, 16'hFFFE},
               {1'b1, 1'b0, 16'h8000}, {1'b1, 1'b1, 16'h7FFF}};
        for (int i = 0; i < 4; i++) begin
            i_a = ta[i]; i_b = tb[i]; i_sub = ts[i]; i_ci = 1'b0; i_valid = 1'b1;
            tick();
            i_valid = 1'b0;
            lat = 1;
            while (o_valid !== 1'b1 && lat < 10) begin
                tick();
                lat++;
            end
            n_tests++;
            if (lat != 4) begin n_fail++; $display("FAIL directed%0d_latency: got %0d expected 4", i, lat); end
            n_tests++;
            if ({o_ovf, o_co, o_s} !== te[i]) begin
                n_fail++;
                $display("FAIL directed%0d_result: got ovf=%b co=%b s=%h expected ovf=%b co=%b s=%h",
                         i, o_ovf, o_co, o_s, te[i][17], te[i][16], te[i][15:0]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] q [$];
        logic [17:0] ex;
        logic        ev;
        for (int e = 0; e < 108; e++) begin
            if (e < 100) begin
                i_a = 16'($urandom); i_b = 16'($urandom);
                i_ci = 1'($urandom); i_sub = 1'($urandom); i_valid = 1'b1;
                q.push_back(ref16(i_a, i_b, i_ci, i_sub));
            end else begin
                i_valid = 1'b0;
            end
            tick();
            ev = (e >= 3 && e < 103);
            n_tests++;
            if (o_valid !== ev) begin n_fail++; $display("FAIL stream_valid edge %0d: got %b expected %b", e, o_valid, ev); end
            if (o_valid === 1'b1 && q.size() > 0) begin
                ex = q.pop_front();
                n_tests++;
                if ({o_ovf, o_co, o_s} !== ex) begin
                    n_fail++;
                    $display("FAIL stream_data edge %0d: got %h expected %h", e, {o_ovf, o_co, o_s}, ex);
                end
            end
        end
        n_tests++;
        if (q.size() != 0) begin n_fail++; $display("FAIL stream_count: got %0d left expected 0", q.size()); end
    endtask

    task automatic test_stall();
        logic [17:0] q [$];
        int          tq [$];
        logic [18:0] snap;
        int          issued, popped, t0, stalls, lat;
        logic        stall;
        issued = 0;
        popped = 0;
        for (int e = 0; e < 24; e++) begin
            stall = (e >= 4 && e <= 6);
            snap  = {o_valid, o_ovf, o_co, o_s};
            if (stall) begin
                en = 1'b0; i_valid = 1'b0;
            end else begin
                en = 1'b1;
                if (issued < 8) begin
                    i_a = 16'($urandom); i_b = 16'($urandom);
                    i_ci = 1'($urandom); i_sub = 1'($urandom); i_valid = 1'b1;
                    q.push_back(ref16(i_a, i_b, i_ci, i_sub));
                    tq.push_back(e);
                    issued++;
                end else begin
                    i_valid = 1'b0;
                end
            end
            tick();
            if (stall) begin
                n_tests++;
                if ({o_valid, o_ovf, o_co, o_s} !== snap) begin
                    n_fail++;
                    $display("FAIL stall_frozen edge %0d: got %h expected %h", e, {o_valid, o_ovf, o_co, o_s}, snap);
                end
            end else if (o_valid === 1'b1) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL stall_extra edge %0d: got result expected none", e);
                end else begin
                    t0 = tq.pop_front();
                    popped++;
                    stalls = 0;
                    for (int x = t0 + 1; x <= e; x++) if (x >= 4 && x <= 6) stalls++;
                    lat = e - t0 + 1;
                    if ({o_ovf, o_co, o_s} !== q[0] || lat != 4 + stalls) begin
                        n_fail++;
                        $display("FAIL stall_result edge %0d: got %h lat %0d expected %h lat %0d",
                                 e, {o_ovf, o_co, o_s}, lat, q[0], 4 + stalls);
                    end
                    void'(q.pop_front());
                end
            end
        end
        en = 1'b1;
        n_tests++;
        if (popped != 8) begin n_fail++; $display("FAIL stall_count: got %0d expected 8", popped); end
    endtask

    task automatic test_reset_mid();
        for (int e = 0; e < 3; e++) begin
            i_a = 16'h1000 + 16'(e); i_b = 16'h0100; i_ci = 1'b0; i_sub = 1'b0; i_valid = 1'b1;
            tick();
        end
        rst = 1'b1; i_a = 16'hAAAA; i_b = 16'h5555; i_valid = 1'b1;
        tick();
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid edge 3: got %b expected 0", o_valid); end
        rst = 1'b0; i_a = 16'h1234; i_b = 16'h4321; i_ci = 1'b1; i_sub = 1'b0; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid edge 4: got %b expected 0", o_valid); end
        for (int e = 5; e < 7; e++) begin
            tick();
            n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid edge %0d: got %b expected 0", e, o_valid); end
        end
        tick();
        n_tests++;
        if ({o_valid, o_ovf, o_co, o_s} !== {1'b1, 1'b0, 1'b0, 16'h5556}) begin
            n_fail++;
            $display("FAIL rstmid_result: got v=%b ovf=%b co=%b s=%h expected v=1 ovf=0 co=0 s=5556", o_valid, o_ovf, o_co, o_s);
        end
        tick();
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_tail: got %b expected 0", o_valid); end
    endtask

    task automatic test_sweep();
        logic [7:0] bv [16];
        int         mode, j;
        bv = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF,
               8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h3C, 8'hC3, 8'h10, 8'hEF};
        w_en = 1'b1;
        for (int e = 0; e < NSW + 8; e++) begin
            if (e < NSW) begin
                mode  = (e >> 12) & 3;
                w_a   = 8'((e >> 4) & 255);
                w_b   = bv[e & 15];
                w_sub = mode[1];
                w_ci  = mode[0];
                w_valid = 1'b1;
                e8[e] = ref8(w_a, w_b, w_ci, w_sub);
            end else begin
                w_valid = 1'b0;
            end
            tick();
            j = e;
            if (j < NSW) begin
                n_tests++;
                if ({v1, ov1, co1, s1} !== {1'b1, e8[j]}) begin
                    n_fail++; $display("FAIL sweep_seg1 op %0d: got %h expected %h", j, {v1, ov1, co1, s1}, {1'b1, e8[j]});
                end
            end
            j = e - 1;
            if (j >= 0 && j < NSW) begin
                n_tests++;
                if ({v2, ov2, co2, s2} !== {1'b1, e8[j]}) begin
                    n_fail++; $display("FAIL sweep_seg2 op %0d: got %h expected %h", j, {v2, ov2, co2, s2}, {1'b1, e8[j]});
                end
            end
            j = e - 7;
            if (j >= 0 && j < NSW) begin
                n_tests++;
                if ({v8, ov8, co8, s8} !== {1'b1, e8[j]}) begin
                    n_fail++; $display("FAIL sweep_seg8 op %0d: got %h expected %h", j, {v8, ov8, co8, s8}, {1'b1, e8[j]});
                end
            end
        end
        n_tests++;
        if ({v1, v2, v8} !== 3'b000) begin n_fail++; $display("FAIL sweep_drain: got %b expected 000", {v1, v2, v8}); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; i_valid = 1'b0; i_a = '0; i_b = '0; i_ci = 1'b0; i_sub = 1'b0;
        w_rst = 1'b1; w_en = 1'b1; w_valid = 1'b0; w_a = '0; w_b = '0; w_ci = 1'b0; w_sub = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
